// File: rtl/alu_arbitro_if.sv
// Bundle of requester, shared-ALU and response signals around alu_arbitro.
// The master side is the environment (requesters, ALU, consumer); the slave side is the arbiter.
interface alu_arbitro_if #(
  parameter int ANCHO = 4
);
  // Handshakes: a transfer happens in a cycle where valid and ready are both 1.
  // Requester k holds req_valid_i[k]; the arbiter answers with req_ready_o[k] in that cycle.
  // The arbiter holds resp_valid_o and the response fields stable until resp_ready_i is 1.
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [2*ANCHO-1:0] req_a_i;
  logic [2*ANCHO-1:0] req_b_i;
  logic [1:0]         req_flagin_i;
  logic [7:0]         req_control_i;

  logic [ANCHO-1:0]   alu_a_o;
  logic [ANCHO-1:0]   alu_b_o;
  logic               alu_flagin_o;
  logic [3:0]         alu_control_o;
  logic [ANCHO-1:0]   alu_result_i;
  logic               alu_flags_i;
  logic               alu_zero_i;

  logic               resp_valid_o;
  logic               resp_id_o;
  logic [ANCHO-1:0]   resp_result_o;
  logic               resp_flags_o;
  logic               resp_zero_o;
  logic               resp_error_o;
  logic               resp_ready_i;

  logic [1:0]         state_dbg;

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_flagin_i, req_control_i,
    output alu_result_i, alu_flags_i, alu_zero_i, resp_ready_i,
    input  req_ready_o, alu_a_o, alu_b_o, alu_flagin_o, alu_control_o,
    input  resp_valid_o, resp_id_o, resp_result_o, resp_flags_o, resp_zero_o, resp_error_o,
    input  state_dbg
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_flagin_i, req_control_i,
    input  alu_result_i, alu_flags_i, alu_zero_i, resp_ready_i,
    output req_ready_o, alu_a_o, alu_b_o, alu_flagin_o, alu_control_o,
    output resp_valid_o, resp_id_o, resp_result_o, resp_flags_o, resp_zero_o, resp_error_o,
    output state_dbg
  );
endinterface

// File: rtl/alu_arbitro.sv
// Two-requester round-robin arbiter in front of one shared ALU, one operation in flight.
// Optional macro ALU_ARBITRO_OPCHECK_EN: opcodes above 4'h9 are answered with an error, not executed.
module alu_arbitro #(
  parameter int ANCHO = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbitro_if.slave bus
);
  typedef enum logic [1:0] {
    LIBRE    = 2'd0,
    EJECUTA  = 2'd1,
    RESPONDE = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic [ANCHO-1:0] lat_a;
  logic [ANCHO-1:0] lat_b;
  logic             lat_flagin;
  logic [3:0]       lat_control;
  logic             lat_id;
  logic             resp_id;
  logic [ANCHO-1:0] resp_result;
  logic             resp_flags;
  logic             resp_zero;

  logic             winner;
  logic             grant;
  logic [ANCHO-1:0] sel_a;
  logic [ANCHO-1:0] sel_b;
  logic             sel_flagin;
  logic [3:0]       sel_control;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  always_comb begin
    winner = bus.req_valid_i[1];
    if (bus.req_valid_i == 2'b11) winner = prio;
  end

  assign grant       = !rst_i && (state == LIBRE) && (bus.req_valid_i != 2'b00);
  assign sel_a       = winner ? bus.req_a_i[2*ANCHO-1:ANCHO] : bus.req_a_i[ANCHO-1:0];
  assign sel_b       = winner ? bus.req_b_i[2*ANCHO-1:ANCHO] : bus.req_b_i[ANCHO-1:0];
  assign sel_flagin  = winner ? bus.req_flagin_i[1] : bus.req_flagin_i[0];
  assign sel_control = winner ? bus.req_control_i[7:4] : bus.req_control_i[3:0];

  assign bus.req_ready_o   = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.alu_a_o       = lat_a;
  assign bus.alu_b_o       = lat_b;
  assign bus.alu_flagin_o  = lat_flagin;
  assign bus.alu_control_o = lat_control;
  assign bus.resp_valid_o  = (state == RESPONDE);
  assign bus.resp_id_o     = resp_id;
  assign bus.resp_result_o = resp_result;
  assign bus.resp_flags_o  = resp_flags;
  assign bus.resp_zero_o   = resp_zero;
  assign bus.state_dbg     = state;

  // Only the carry/borrow-style opcodes report the ALU flag.
  function automatic logic keeps_flag(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd6) || (op == 4'd8) || (op == 4'd9);
  endfunction

`ifdef ALU_ARBITRO_OPCHECK_EN
  logic resp_error;
  assign bus.resp_error_o = resp_error;
`else
  assign bus.resp_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= LIBRE;
      prio        <= 1'b0;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_flagin  <= 1'b0;
      lat_control <= 4'd0;
      lat_id      <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= 1'b0;
      resp_zero   <= 1'b0;
`ifdef ALU_ARBITRO_OPCHECK_EN
      resp_error  <= 1'b0;
`endif
    end else begin
      case (state)
        LIBRE: begin
          if (grant) begin
            prio <= ~winner;
`ifdef ALU_ARBITRO_OPCHECK_EN
            // Illegal opcodes never reach the ALU, so its inputs keep their old values.
            if (sel_control > 4'h9) begin
              state       <= RESPONDE;
              resp_id     <= winner;
              resp_result <= '0;
              resp_flags  <= 1'b0;
              resp_zero   <= 1'b1;
              resp_error  <= 1'b1;
            end else
`endif
            begin
              state       <= EJECUTA;
              lat_a       <= sel_a;
              lat_b       <= sel_b;
              lat_flagin  <= sel_flagin;
              lat_control <= sel_control;
              lat_id      <= winner;
            end
          end
        end
        EJECUTA: begin
          state       <= RESPONDE;
          resp_id     <= lat_id;
          resp_result <= bus.alu_result_i;
          resp_zero   <= bus.alu_zero_i;
          resp_flags  <= keeps_flag(lat_control) ? bus.alu_flags_i : 1'b0;
`ifdef ALU_ARBITRO_OPCHECK_EN
          resp_error  <= 1'b0;
`endif
        end
        RESPONDE: begin
          if (bus.resp_ready_i) state <= LIBRE;
        end
        default: state <= LIBRE;
      endcase
    end
  end
endmodule
